// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with a req/ack data port, a timeout abort and one registered writeback record per instruction
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [5:0]            ex_opcode,
  input  logic [31:0]           ex_alu_out,
  input  logic [31:0]           ex_store_data,
  input  logic [4:0]            ex_dest,
  input  logic                  ex_wb_en,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [4:0]            wb_dest,
  output logic [31:0]           wb_data,
  output logic                  wb_fault
);
  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2B;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [4:0] dest;
  logic accept, is_mem, misal, start, done, abort;
  assign ex_ready = state == IDLE;
  assign accept = ex_valid && ex_ready;
  assign is_mem = ex_opcode == LW || ex_opcode == SW;
  assign misal = ex_alu_out[1:0] != 2'b00;
  assign start = accept && is_mem && !misal;
  assign done = state == ACCESS && mem_ack;
  assign abort = state == ACCESS && !mem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  // state register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  // enter ACCESS on an aligned load/store, leave on ack or timeout
  always_comb begin
    state_nx = state;
    state_nx = start ? ACCESS : (done || abort) ? IDLE : state;
  end
  // memory port, timeout counter and the one-cycle writeback record
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_we <= 1'b0;
      wb_fault <= 1'b0;
      wb_dest <= '0;
      wb_data <= '0;
      dest <= '0;
      cnt <= '0;
    end else begin
      wb_valid <= (accept && !start) || done || abort;
      wb_we <= 1'b0;
      wb_fault <= 1'b0;
      if (accept && !start) begin
        wb_dest <= ex_dest;
        wb_data <= ex_alu_out;
        wb_fault <= is_mem;
        wb_we <= !is_mem && ex_wb_en && ex_dest != 5'd0;
      end
      if (start) begin
        mem_req <= 1'b1;
        mem_we <= ex_opcode == SW;
        mem_addr <= ex_alu_out[ADDR_WIDTH-1:0];
        mem_wdata <= ex_store_data;
        dest <= ex_dest;
        cnt <= '0;
      end
      if (state == ACCESS) cnt <= cnt + 1'b1;
      if (done || abort) begin
        mem_req <= 1'b0;
        wb_dest <= dest;
        wb_data <= (done && !mem_we) ? mem_rdata : 32'd0;
        wb_we <= done && !mem_we && dest != 5'd0;
        wb_fault <= abort;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector and sequence checks for mem_stage
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst_n, ex_valid, ex_ready, ex_wb_en, mem_req, mem_we, mem_ack;
  logic wb_valid, wb_we, wb_fault;
  logic [5:0] ex_opcode;
  logic [31:0] ex_alu_out, ex_store_data, mem_wdata, mem_rdata, wb_data, mem_addr;
  logic [4:0] ex_dest, wb_dest;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [5:0] op;
    logic [31:0] alu;
    logic [4:0] dest;
    logic en;
    logic e_we;
    logic e_fault;
  } vec_t;
  vec_t vecs[8];

  mem_stage #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] d, input logic en);
    ex_valid = 1'b1;
    ex_opcode = op;
    ex_alu_out = alu;
    ex_store_data = sd;
    ex_dest = d;
    ex_wb_en = en;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_req"}, 32'(mem_req), 0);
    chk({tag, " mem_we"}, 32'(mem_we), 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
    chk({tag, " wb_valid"}, 32'(wb_valid), 0);
    chk({tag, " wb_we"}, 32'(wb_we), 0);
    chk({tag, " wb_fault"}, 32'(wb_fault), 0);
    chk({tag, " wb_dest"}, 32'(wb_dest), 0);
    chk({tag, " wb_data"}, wb_data, 0);
    chk({tag, " ex_ready"}, 32'(ex_ready), 1);
  endtask

  initial begin
    vecs[0] = '{6'h08, 32'h0000_0010, 5'd5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{6'h08, 32'h0000_ABCD, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{6'h00, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{6'h0D, 32'h0000_1111, 5'd12, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{6'h23, 32'h0000_0102, 5'd8, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{6'h2B, 32'h0000_0201, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{6'h2B, 32'h0000_0203, 5'd2, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{6'h08, 32'h0000_0003, 5'd1, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0;
    ex_valid = 1'b0;
    ex_opcode = '0;
    ex_alu_out = '0;
    ex_store_data = '0;
    ex_dest = '0;
    ex_wb_en = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].alu, 32'h5A5A_0000, vecs[i].dest, vecs[i].en);
      @(negedge clk);
      ex_valid = 1'b0;
      chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 1);
      chk($sformatf("v%0d wb_we", i), 32'(wb_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d wb_fault", i), 32'(wb_fault), 32'(vecs[i].e_fault));
      chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].alu);
      chk($sformatf("v%0d wb_dest", i), 32'(wb_dest), 32'(vecs[i].dest));
      chk($sformatf("v%0d mem_req", i), 32'(mem_req), 0);
      chk($sformatf("v%0d ex_ready", i), 32'(ex_ready), 1);
      @(negedge clk);
      chk($sformatf("v%0d idle wb_valid", i), 32'(wb_valid), 0);
      chk($sformatf("v%0d idle wb_we", i), 32'(wb_we), 0);
    end

    // LW acked in the third request cycle; a held ADDI waits until ready returns
    @(negedge clk);
    drive(6'h23, 32'h0000_0100, 32'h0, 5'd7, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) drive(6'h08, 32'h0000_0055, 32'h0, 5'd9, 1'b1);
      chk($sformatf("lw c%0d mem_req", c), 32'(mem_req), 1);
      chk($sformatf("lw c%0d mem_we", c), 32'(mem_we), 0);
      chk($sformatf("lw c%0d mem_addr", c), mem_addr, 32'h100);
      chk($sformatf("lw c%0d ex_ready", c), 32'(ex_ready), 0);
      chk($sformatf("lw c%0d wb_valid", c), 32'(wb_valid), 0);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    chk("lw wb_valid", 32'(wb_valid), 1);
    chk("lw wb_data", wb_data, 32'hDEAD_BEEF);
    chk("lw wb_we", 32'(wb_we), 1);
    chk("lw wb_dest", 32'(wb_dest), 7);
    chk("lw wb_fault", 32'(wb_fault), 0);
    chk("lw mem_req", 32'(mem_req), 0);
    chk("lw ex_ready", 32'(ex_ready), 1);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("held addi wb_valid", 32'(wb_valid), 1);
    chk("held addi wb_data", wb_data, 32'h55);
    chk("held addi wb_dest", 32'(wb_dest), 9);
    chk("held addi wb_we", 32'(wb_we), 1);

    // SW acked in its first request cycle
    @(negedge clk);
    drive(6'h2B, 32'h0000_0204, 32'h0000_1234, 5'd3, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("sw mem_req", 32'(mem_req), 1);
    chk("sw mem_we", 32'(mem_we), 1);
    chk("sw mem_addr", mem_addr, 32'h204);
    chk("sw mem_wdata", mem_wdata, 32'h1234);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("sw wb_valid", 32'(wb_valid), 1);
    chk("sw wb_we", 32'(wb_we), 0);
    chk("sw wb_fault", 32'(wb_fault), 0);
    chk("sw wb_data", wb_data, 0);

    // LW never acked: four request cycles then a fault record
    @(negedge clk);
    drive(6'h23, 32'h0000_0300, 32'h0, 5'd4, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      chk($sformatf("to c%0d mem_req", c), 32'(mem_req), 1);
      chk($sformatf("to c%0d wb_valid", c), 32'(wb_valid), 0);
    end
    @(negedge clk);
    chk("to mem_req", 32'(mem_req), 0);
    chk("to wb_valid", 32'(wb_valid), 1);
    chk("to wb_fault", 32'(wb_fault), 1);
    chk("to wb_we", 32'(wb_we), 0);
    chk("to ex_ready", 32'(ex_ready), 1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray ack wb_valid", 32'(wb_valid), 0);
    chk("stray ack mem_req", 32'(mem_req), 0);
    chk("stray ack ex_ready", 32'(ex_ready), 1);

    // reset in the middle of an access; the late ack must be ignored
    @(negedge clk);
    drive(6'h2B, 32'h0000_0400, 32'h0000_9999, 5'd6, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rst mid mem_req", 32'(mem_req), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("rst mid");
    rst_n = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late ack wb_valid", 32'(wb_valid), 0);
    chk("late ack mem_req", 32'(mem_req), 0);
    chk("late ack ex_ready", 32'(ex_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage directly downstream of the ALU in the MIPS datapath. It consumes the ALU result and opcode.
- For LW/SW, the ALU result is the effective address; the stage runs a req/ack transaction on the data-memory port.
- For all other opcodes, the ALU result passes through to writeback.
- Produces one registered writeback record per accepted instruction and back-pressures the execute stage while a memory transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req stays high without mem_ack before the access is aborted as a bus fault (>=1)
ADDR_WIDTH, 32, width of mem_addr; taken from the low bits of the ALU result

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
ex_valid  in  1  execute stage presents an instruction
ex_ready  out  1  stage can accept an instruction this cycle
ex_opcode  in  6  instruction opcode (LW=6'h23, SW=6'h2B, others non-memory)
ex_alu_out  in  32  ALU result (address for LW/SW, value otherwise)
ex_store_data  in  32  rt value for SW
ex_dest  in  5  destination register index
ex_wb_en  in  1  non-memory instruction writes its destination register
mem_req  out  1  memory request, held until ack or timeout
mem_we  out  1  1 = store, 0 = load; valid while mem_req
mem_addr  out  ADDR_WIDTH  word-aligned byte address; valid while mem_req
mem_wdata  out  32  store data; valid while mem_req
mem_rdata  in  32  load data, sampled in the mem_ack cycle
mem_ack  in  1  one-cycle completion strobe
wb_valid  out  1  one-cycle pulse: writeback record valid
wb_we  out  1  register-file write enable for this record
wb_dest  out  5  destination register
wb_data  out  32  value to write
wb_fault  out  1  misaligned address or bus timeout

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - mem_req, mem_we, wb_valid, wb_we and wb_fault go to 0.
  - mem_addr, mem_wdata, wb_dest and wb_data go to 0.
  - The internal timeout counter goes to 0.
  - Reset during ACCESS drops mem_req at that edge; a later mem_ack is ignored.
- States: IDLE and ACCESS. ex_ready = (state==IDLE). An instruction is accepted on an edge where ex_valid && ex_ready.
- Accept, non-memory opcode:
  - Next cycle: wb_valid=1, wb_data=ex_alu_out, wb_dest=ex_dest, wb_fault=0.
  - wb_we = ex_wb_en && ex_dest!=0.
  - Latency 1. State stays IDLE, so back-to-back acceptance is possible every cycle.
- Accept, LW/SW with ex_alu_out[1:0]!=0 (misaligned):
  - No memory request.
  - Next cycle: wb_valid=1, wb_fault=1, wb_we=0, wb_data=ex_alu_out, wb_dest=ex_dest.
- Accept, aligned LW/SW:
  - On the same edge, register mem_req=1, mem_we=(opcode==SW), mem_addr=ex_alu_out[ADDR_WIDTH-1:0], mem_wdata=ex_store_data.
  - Store the destination, clear the counter, and go to ACCESS.
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1.
- ACCESS:
  - mem_ack=1 at an edge: mem_req goes to 0 and state goes to IDLE. Next cycle wb_valid=1, wb_fault=0, and:
    - LW: wb_data=mem_rdata (sampled at that edge), wb_we=(dest!=0).
    - SW: wb_data=0, wb_we=0.
  - mem_ack=0 and counter==TIMEOUT_CYCLES-1: abort. mem_req goes to 0, state goes to IDLE, and next cycle wb_valid=1, wb_fault=1, wb_we=0.
  - Otherwise the counter increments.
- Minimum memory latency: accept at edge N, mem_req high in cycle N+1, ack sampled at edge N+1, wb_valid in cycle N+2, ex_ready high again in cycle N+2.
- mem_ack while IDLE is ignored.
- ex_valid while in ACCESS is not consumed; the execute stage holds its inputs.
- wb_valid is high for exactly one cycle per accepted instruction. In cycles without a record, wb_valid=0 and wb_we=0 (wb_we is never 1 while wb_valid=0).

Test Plan:
- Reset, then ex_valid with ADDI-class opcode 6'h08, alu_out=32'h0000_0010, dest=5, wb_en=1 -> next cycle wb_valid=1, wb_we=1, wb_dest=5, wb_data=32'h10, mem_req stays 0.
- Non-memory op with dest=0 and wb_en=1 -> wb_valid=1, wb_we=0.
- LW at address 32'h100, ack 3 cycles after mem_req with rdata=32'hDEADBEEF:
  - mem_req=1, mem_we=0, mem_addr=32'h100 held for 3 cycles; ex_ready=0 throughout.
  - wb_data=32'hDEADBEEF, wb_we=1 in the cycle after ack.
- SW at address 32'h204, store_data=32'h1234, ack in the first cycle:
  - mem_we=1, mem_wdata=32'h1234.
  - wb_valid=1 with wb_we=0 two cycles after accept.
- LW at address 32'h102 -> no mem_req; next cycle wb_valid=1, wb_fault=1, wb_we=0.
- Two further cases:
  - TIMEOUT_CYCLES=4, LW never acked -> mem_req high exactly 4 cycles, then wb_fault=1 pulse, ex_ready=1. A stray mem_ack afterwards is ignored.
  - rst_n=0 mid-ACCESS -> all outputs 0 at that edge.
